trivium_ctrl: RTL and testbench

//   Sequencer for the Trivium keystream core inside tt_um_trivium_top.
//   - Collects the 80-bit key and 80-bit IV as bytes over a command port.
//   - Loads them into the core and runs the 4*288 warm-up clocks.
//   - Then produces keystream bytes (8 core steps each) behind a valid/ready handshake.
//   - The core holds the 288-bit state; this block owns the schedule.

---
 rtl/trivium_pkg.sv | 36 +++
 rtl/trivium_step_counter.sv | 47 ++++
 rtl/trivium_ctrl.sv | 139 +++++++++++++
 tb/tb_trivium_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// trivium_pkg
//   Shared constants and types for the Trivium sequencer.
//   - KEY_BITS / IV_BITS : shadow register widths
//   - WARMUP_CYCLES      : core steps between load and first keystream bit
//   - BYTE_BITS          : core steps per keystream byte
//   - CNT_W              : width of the shared step down-counter
//   - cmd_op_e           : command opcodes on the command port
//   - state_e            : sequencer FSM states
package trivium_pkg;

  localparam int KEY_BITS      = 80;
  localparam int IV_BITS       = 80;
  localparam int WARMUP_CYCLES = 1152;
  localparam int BYTE_BITS     = 8;
  localparam int CNT_W         = 11;

  // The counter runs N-1 .. 0, so each phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] WARMUP_LOAD = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GEN_LOAD    = CNT_W'(BYTE_BITS - 1);

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_KEY   = 2'b01,
    OP_IV    = 2'b10,
    OP_START = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WARMUP = 3'd2,
    ST_GEN    = 3'd3,
    ST_VALID  = 3'd4
  } state_e;

endpackage

// File: rtl/trivium_step_counter.sv
// trivium_step_counter
//   Loadable down-counter shared by the warm-up phase and the per-byte
//   generation phase. Load has priority over decrement; the count never
//   wraps below zero.
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset (count -> 0)
//   load_i      in   load load_val_i this cycle
//   load_val_i  in   value to load
//   dec_i       in   decrement this cycle (ignored while loading)
//   zero_o      out  count is zero
module trivium_step_counter
  import trivium_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/trivium_ctrl.sv
// trivium_ctrl
//   Sequencer for the Trivium keystream core. Collects key/IV bytes,
//   loads the core, runs the warm-up, then assembles keystream bytes.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 0 freezes FSM, counters and core stepping
//   cmd_valid/cmd_ready command handshake; cmd_op (NOP/KEY/IV/START), cmd_data
//   ks_byte/ks_valid    keystream byte out, first generated bit in [7]
//   ks_ready            consumer ready
//   busy                1 in LOAD/WARMUP/GEN
//   core_key, core_iv   shadow registers driven to the core
//   core_load           core loads key/iv this cycle
//   core_step           core advances one clock this cycle
//   core_ks             core keystream bit for its current state
//   dbg_state           current FSM state (state_e encoding)
//
// Handshakes: a transfer happens on a rising edge where valid & ready & ena
// are all high. cmd_ready depends only on state; ks_valid stays high and
// ks_byte stays stable until the byte is taken or a START discards it.
module trivium_ctrl
  import trivium_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_op,
  input  logic [7:0]          cmd_data,
  output logic                cmd_ready,
  output logic [7:0]          ks_byte,
  output logic                ks_valid,
  input  logic                ks_ready,
  output logic                busy,
  output logic [KEY_BITS-1:0] core_key,
  output logic [IV_BITS-1:0]  core_iv,
  output logic                core_load,
  output logic                core_step,
  input  logic                core_ks,
  output logic [2:0]          dbg_state
);

  state_e              state_q;
  logic [KEY_BITS-1:0] key_q;
  logic [IV_BITS-1:0]  iv_q;
  logic [7:0]          ks_shift_q;

  logic             cmd_fire;
  logic             key_wr;
  logic             iv_wr;
  logic             start;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_VALID);
  assign cmd_fire  = cmd_valid && cmd_ready && ena;
  assign key_wr    = cmd_fire && (cmd_op == OP_KEY);
  assign iv_wr     = cmd_fire && (cmd_op == OP_IV);
  assign start     = cmd_fire && (cmd_op == OP_START);

  // Counter control: LOAD arms the warm-up, the last warm-up cycle arms the
  // first byte, and a consumed byte in VALID arms the next one.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = GEN_LOAD;
    cnt_dec  = 1'b0;
    if (ena) begin
      case (state_q)
        ST_LOAD: begin
          cnt_load = 1'b1;
          cnt_val  = WARMUP_LOAD;
        end
        ST_WARMUP: begin
          if (cnt_zero) cnt_load = 1'b1;
          else          cnt_dec  = 1'b1;
        end
        ST_GEN:   cnt_dec = 1'b1;
        ST_VALID: cnt_load = ks_ready && !start;
        default:  ;
      endcase
    end
  end

  trivium_step_counter #(.W(CNT_W)) u_step_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      iv_q       <= '0;
      ks_shift_q <= '0;
    end else begin
      // Shadow writes shift in from the top so byte 0 ends up in [7:0];
      // they reach the core only at the next LOAD.
      if (key_wr) key_q <= {cmd_data, key_q[KEY_BITS-1:8]};
      if (iv_wr)  iv_q  <= {cmd_data, iv_q[IV_BITS-1:8]};
      if (ena) begin
        case (state_q)
          ST_IDLE: begin
            if (start) state_q <= ST_LOAD;
          end
          ST_LOAD: state_q <= ST_WARMUP;
          ST_WARMUP: begin
            if (cnt_zero) state_q <= ST_GEN;
          end
          ST_GEN: begin
            ks_shift_q <= {ks_shift_q[6:0], core_ks};
            if (cnt_zero) state_q <= ST_VALID;
          end
          ST_VALID: begin
            // START beats a simultaneous ks_ready; the held byte is dropped.
            if (start)         state_q <= ST_LOAD;
            else if (ks_ready) state_q <= ST_GEN;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign ks_byte   = ks_shift_q;
  assign ks_valid  = (state_q == ST_VALID);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_WARMUP) || (state_q == ST_GEN);
  assign core_key  = key_q;
  assign core_iv   = iv_q;
  // Gated by ena so a frozen LOAD does not reload and a frozen run does not step.
  assign core_load = ena && (state_q == ST_LOAD);
  assign core_step = ena && ((state_q == ST_WARMUP) || (state_q == ST_GEN));
  assign dbg_state = state_q;

endmodule

// File: tb/tb_trivium_ctrl.sv
module tb_trivium_ctrl;
  import trivium_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         rst_n;
  logic         ena;
  logic         cmd_valid;
  logic [1:0]   cmd_op;
  logic [7:0]   cmd_data;
  logic         cmd_ready;
  logic [7:0]   ks_byte;
  logic         ks_valid;
  logic         ks_ready;
  logic         busy;
  logic [79:0]  core_key;
  logic [79:0]  core_iv;
  logic         core_load;
  logic         core_step;
  logic         core_ks;
  logic [2:0]   dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  trivium_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .ks_byte   (ks_byte),
    .ks_valid  (ks_valid),
    .ks_ready  (ks_ready),
    .busy      (busy),
    .core_key  (core_key),
    .core_iv   (core_iv),
    .core_load (core_load),
    .core_step (core_step),
    .core_ks   (core_ks),
    .dbg_state (dbg_state)
  );

  // ---------------- behavioural Trivium core ----------------
  // st[i-1] holds Trivium state bit s_i.
  function automatic logic triv_z(input logic [287:0] s);
    return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
  endfunction

  function automatic logic [287:0] triv_step(input logic [287:0] s);
    logic t1, t2, t3;
    logic [287:0] n;
    t1 = s[65]  ^ s[92]  ^ (s[90]  & s[91])  ^ s[170];
    t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
    t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
    n[92:0]    = {s[91:0], t3};
    n[176:93]  = {s[175:93], t1};
    n[287:177] = {s[286:177], t2};
    return n;
  endfunction

  function automatic logic [287:0] triv_load(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] n;
    n          = '0;
    n[79:0]    = k;
    n[172:93]  = v;
    n[287:285] = 3'b111;
    return n;
  endfunction

  logic [287:0] core_st;
  always @(posedge clk) begin
    if (core_load)      core_st <= triv_load(core_key, core_iv);
    else if (core_step) core_st <= triv_step(core_st);
  end
  assign core_ks = triv_z(core_st);

  // ---------------- monitor (samples the cycle that just ended) ----------------
  int cyc = 0;
  int load_cnt = 0, step_cnt = 0, both_cnt = 0;
  int last_load_cyc = -1, first_step_cyc = -1, last_step_cyc = -1;
  logic prev_load = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_load <= core_load;
    if (core_load) begin
      load_cnt      <= load_cnt + 1;
      last_load_cyc <= cyc;
    end
    if (core_step) begin
      step_cnt      <= step_cnt + 1;
      last_step_cyc <= cyc;
      if (prev_load) first_step_cyc <= cyc;
    end
    if (core_load && core_step) both_cnt <= both_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic build_expected(input logic [79:0] k, input logic [79:0] v, input int nbytes);
    logic [287:0] s;
    logic [7:0]   b;
    exp_q.delete();
    s = triv_load(k, v);
    repeat (WARMUP_CYCLES) s = triv_step(s);
    for (int i = 0; i < nbytes; i++) begin
      b = '0;
      for (int j = 0; j < 8; j++) begin
        b = {b[6:0], triv_z(s)};
        s = triv_step(s);
      end
      exp_q.push_back(b);
    end
  endtask

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  int last_cmd_cyc;

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!(cmd_ready && ena) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready", 128'(cmd_ready), 128'(1));
    last_cmd_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!ks_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 128'(ks_valid), 128'(1));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] exp_key_top;
    logic [7:0] exp_iv_top;
  } vec_t;

  localparam logic [79:0] KEY1 = 80'h09080706050403020100;
  localparam logic [79:0] IV1  = 80'hA9A8A7A6A5A4A3A2A1A0;

  vec_t vecs[21];

  // ---------------- test ----------------
  initial begin : main
    int t, l0, s0, s1, prev_cons;
    logic [7:0] first_byte, b0;

    for (int i = 0; i < 10; i++) vecs[i] = '{2'b01, 8'(i), 8'(i), 8'h00};
    for (int i = 10; i < 20; i++) vecs[i] = '{2'b10, 8'hA0 + 8'(i - 10), 8'h09, 8'hA0 + 8'(i - 10)};
    vecs[20] = '{2'b00, 8'h55, 8'h09, 8'hA9};

    rst_n = 1'b1; ena = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; ks_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // 1. reset values
    chk("rst_ks_valid",  128'(ks_valid),  128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("rst_core_key",  128'(core_key),  128'(0));
    chk("rst_core_iv",   128'(core_iv),   128'(0));
    chk("rst_core_load", 128'(core_load), 128'(0));
    chk("rst_core_step", 128'(core_step), 128'(0));
    chk("rst_ks_byte",   128'(ks_byte),   128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 2. key / IV loading from the table
    l0 = load_cnt;
    for (int i = 0; i < 21; i++) begin
      send_cmd(vecs[i].op, vecs[i].data);
      chk("tbl_key_top", 128'(core_key[79:72]), 128'(vecs[i].exp_key_top));
      chk("tbl_iv_top",  128'(core_iv[79:72]),  128'(vecs[i].exp_iv_top));
      chk("tbl_busy",    128'(busy),            128'(0));
    end
    chk("key_full",      128'(core_key),       128'(KEY1));
    chk("iv_full",       128'(core_iv),        128'(IV1));
    chk("no_early_load", 128'(load_cnt - l0),  128'(0));

    // 3. first keystream byte and its timing
    build_expected(KEY1, IV1, 20);
    first_byte = exp_q[0];
    l0 = load_cnt; s0 = step_cnt;
    send_cmd(2'b11, 8'h00);
    t = last_cmd_cyc;
    chk("busy_after_start", 128'(busy), 128'(1));
    wait_valid("first_valid", 1400);
    chk("valid_rise_cyc",  128'(cyc),            128'(t + 1162));
    chk("load_cyc",        128'(last_load_cyc),  128'(t + 1));
    chk("load_count",      128'(load_cnt - l0),  128'(1));
    chk("step_count",      128'(step_cnt - s0),  128'(1160));
    chk("first_step_cyc",  128'(first_step_cyc), 128'(t + 2));
    chk("last_step_cyc",   128'(last_step_cyc),  128'(t + 1161));
    chk("first_byte",      128'(ks_byte),        128'(exp_q[0]));

    // 4. back-pressure, then 16 more bytes at full rate
    b0 = ks_byte;
    s0 = step_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_valid", 128'(ks_valid),  128'(1));
      chk("hold_byte",  128'(ks_byte),   128'(b0));
      chk("hold_step",  128'(core_step), 128'(0));
    end
    chk("hold_step_count", 128'(step_cnt - s0), 128'(0));
    ks_ready = 1'b1;
    chk("byte_0", 128'(ks_byte), 128'(exp_q.pop_front()));
    prev_cons = cyc;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      wait_valid("stream_valid", 20);
      chk("stream_byte",    128'(ks_byte),         128'(exp_q.pop_front()));
      chk("stream_spacing", 128'(cyc - prev_cons), 128'(9));
      prev_cons = cyc;
    end
    @(negedge clk);
    ks_ready = 1'b0;

    // key write while VALID: shadow moves, keystream stays on the old key
    wait_valid("valid_17", 20);
    send_cmd(2'b01, 8'hFF);
    chk("wr_in_valid_key", 128'(core_key[79:72]), 128'(8'hFF));
    chk("wr_in_valid_kv",  128'(ks_valid),        128'(1));
    chk("wr_in_valid_kb",  128'(ks_byte),         128'(exp_q[0]));
    ks_ready = 1'b1;
    chk("byte_17", 128'(ks_byte), 128'(exp_q.pop_front()));
    @(negedge clk);
    wait_valid("valid_18", 20);
    chk("byte_18_old_key", 128'(ks_byte), 128'(exp_q.pop_front()));
    ks_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_cmd(2'b01, 8'(i));
    chk("key_restored", 128'(core_key), 128'(KEY1));

    // 5. START in VALID together with ks_ready, ena dropped mid-WARMUP
    ks_ready = 1'b1;
    l0 = load_cnt; s0 = step_cnt;
    send_cmd(2'b11, 8'h00);
    t = last_cmd_cyc;
    ks_ready = 1'b0;
    chk("restart_kv",   128'(ks_valid),  128'(0));
    chk("restart_load", 128'(core_load), 128'(1));
    repeat (100) @(negedge clk);
    ena = 1'b0;
    s1 = step_cnt;
    repeat (50) @(negedge clk);
    chk("ena_off_steps", 128'(step_cnt - s1), 128'(0));
    ena = 1'b1;
    wait_valid("ena_valid", 1400);
    chk("ena_rise_cyc",   128'(cyc),            128'(t + 1162 + 50));
    chk("ena_step_count", 128'(step_cnt - s0),  128'(1160));
    chk("ena_load_count", 128'(load_cnt - l0),  128'(1));
    chk("ena_last_step",  128'(last_step_cyc),  128'(t + 1161 + 50));
    chk("ena_first_byte", 128'(ks_byte),        128'(first_byte));

    // 6a. plain START in VALID gives the same first byte
    send_cmd(2'b11, 8'h00);
    t = last_cmd_cyc;
    wait_valid("restart_valid", 1400);
    chk("restart_rise_cyc", 128'(cyc),     128'(t + 1162));
    chk("restart_byte",     128'(ks_byte), 128'(first_byte));

    // 6b. reset in the middle of WARMUP
    send_cmd(2'b11, 8'h00);
    repeat (100) @(negedge clk);
    chk("pre_reset_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state",     128'(dbg_state), 128'(ST_IDLE));
    chk("mid_rst_busy",      128'(busy),      128'(0));
    chk("mid_rst_ks_valid",  128'(ks_valid),  128'(0));
    chk("mid_rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("mid_rst_core_step", 128'(core_step), 128'(0));
    chk("mid_rst_core_load", 128'(core_load), 128'(0));
    chk("mid_rst_key",       128'(core_key),  128'(0));
    chk("mid_rst_iv",        128'(core_iv),   128'(0));
    chk("mid_rst_ks_byte",   128'(ks_byte),   128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 128'(busy),      128'(0));
    chk("post_rst_step", 128'(core_step), 128'(0));

    chk("load_step_overlap", 128'(both_cnt), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
